// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous data memory, with a bounded ownership lock for atomics.
// Build option DMEM_ARB_RR_EN: round-robin tie-break when defined, fixed port0 priority otherwise.
`timescale 1ns/1ps
module data_mem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic              p0_lock_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    output logic              p0_gnt_o,
    output logic              p0_rvalid_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic              p1_lock_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p1_gnt_o,
    output logic              p1_rvalid_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    // state | meaning
    // IDLE  | no lock held; arbitrate between both ports
    // OWN0  | port0 holds the lock; port1 stalls
    // OWN1  | port1 holds the lock; port0 stalls
    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic             rsp_valid, rsp_tag;
    logic             tie_p1;

`ifdef DMEM_ARB_RR_EN
    logic rr_last, rr_last_nxt;
    assign tie_p1 = ~rr_last;
`else
    assign tie_p1 = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            lock_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_tag   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_last   <= 1'b1;
`endif
        end else begin
            state     <= state_nxt;
            lock_cnt  <= lock_cnt_nxt;
            rsp_valid <= mem_req_o;
            rsp_tag   <= p1_gnt_o;
`ifdef DMEM_ARB_RR_EN
            rr_last   <= rr_last_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
`ifdef DMEM_ARB_RR_EN
        rr_last_nxt  = rr_last;
`endif
        case (state)
            IDLE: begin
                if (p0_gnt_o && p0_lock_i) begin
                    state_nxt    = OWN0;
                    lock_cnt_nxt = '0;
                end else if (p1_gnt_o && p1_lock_i) begin
                    state_nxt    = OWN1;
                    lock_cnt_nxt = '0;
                end
`ifdef DMEM_ARB_RR_EN
                if (p0_req_i && p1_req_i)
                    rr_last_nxt = p1_gnt_o;
`endif
            end
            OWN0: begin
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
                // Forced release hands the next tie to the port that was stalled.
                if (lock_cnt == CNT_LAST) begin
                    state_nxt = IDLE;
`ifdef DMEM_ARB_RR_EN
                    rr_last_nxt = 1'b0;
`endif
                end else if (!p0_lock_i && (p0_gnt_o || !p0_req_i)) begin
                    state_nxt = IDLE;
                end
            end
            OWN1: begin
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
                if (lock_cnt == CNT_LAST) begin
                    state_nxt = IDLE;
`ifdef DMEM_ARB_RR_EN
                    rr_last_nxt = 1'b1;
`endif
                end else if (!p1_lock_i && (p1_gnt_o || !p1_req_i)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are held low while reset is asserted so nothing reaches memory.
    always_comb begin
        p0_gnt_o = 1'b0;
        p1_gnt_o = 1'b0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    if (p0_req_i && p1_req_i) begin
                        p0_gnt_o = ~tie_p1;
                        p1_gnt_o = tie_p1;
                    end else begin
                        p0_gnt_o = p0_req_i;
                        p1_gnt_o = p1_req_i;
                    end
                end
                OWN0:    p0_gnt_o = p0_req_i;
                OWN1:    p1_gnt_o = p1_req_i;
                default: ;
            endcase
        end
    end

    assign mem_req_o = p0_gnt_o | p1_gnt_o;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (p0_gnt_o) begin
            mem_we_o    = p0_we_i;
            mem_addr_o  = p0_addr_i;
            mem_wdata_o = p0_wdata_i;
        end else if (p1_gnt_o) begin
            mem_we_o    = p1_we_i;
            mem_addr_o  = p1_addr_i;
            mem_wdata_o = p1_wdata_i;
        end
    end

    assign p0_rvalid_o = rsp_valid & ~rsp_tag;
    assign p1_rvalid_o = rsp_valid & rsp_tag;
    assign p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : '0;
    assign p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural ownership/response model and a memory model.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
    localparam int LM = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        p0_req_i, p0_we_i, p0_lock_i, p1_req_i, p1_we_i, p1_lock_i;
    logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
    logic        p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [0:4095];
    logic [31:0] exp_mem [0:4095];

    // model: -1 = nobody owns the memory, else owning port
    int          m_owner, m_held, m_last;
    bit          m_g0, m_g1;
    bit          cur_v;
    int          cur_tag;
    logic [31:0] cur_data;

    always #5 clk_i = ~clk_i;

    data_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .LOCK_MAX(LM)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_lock_i(p0_lock_i),
        .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
        .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_lock_i(p1_lock_i),
        .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
        .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory: 16 KiB in range, writes ack 0xfa111eaf, out-of-range reads 0xdeadbeef.
    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                if (mem_addr_o < 32'h4000) mem[mem_addr_o[13:2]] <= mem_wdata_o;
                mem_rdata_i <= 32'hfa11_1eaf;
            end else begin
                mem_rdata_i <= (mem_addr_o < 32'h4000) ? mem[mem_addr_o[13:2]] : 32'hdead_beef;
            end
        end else begin
            mem_rdata_i <= $urandom;
        end
    end

    always @(negedge clk_i) begin
        bit          g0, g1, we, lk, rq, gn;
        logic [31:0] a, wd, nd;
        if (rst_i) begin
            m_owner = -1; m_held = 0; m_last = 1; cur_v = 0; m_g0 = 0; m_g1 = 0;
            chk("rst_ctrl", {p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, mem_req_o}, 0);
            chk("rst_rdata", {p0_rdata_o, p1_rdata_o}, 0);
        end else begin
            g0 = 0; g1 = 0;
            if (m_owner == 0) g0 = p0_req_i;
            else if (m_owner == 1) g1 = p1_req_i;
            else if (p0_req_i && p1_req_i) begin
`ifdef DMEM_ARB_RR_EN
                if (m_last == 0) g1 = 1; else g0 = 1;
`else
                g0 = 1;
`endif
            end else begin
                g0 = p0_req_i; g1 = p1_req_i;
            end
            we = g0 ? p0_we_i   : (g1 ? p1_we_i   : 1'b0);
            a  = g0 ? p0_addr_i : (g1 ? p1_addr_i : 32'h0);
            wd = g0 ? p0_wdata_i: (g1 ? p1_wdata_i: 32'h0);
            chk("gnt", {p0_gnt_o, p1_gnt_o}, {g0, g1});
            chk("mem_req", mem_req_o, g0 | g1);
            chk("mem_we", mem_we_o, we);
            chk("mem_addr", mem_addr_o, a);
            chk("mem_wdata", mem_wdata_o, wd);
            chk("rvalid", {p0_rvalid_o, p1_rvalid_o}, {cur_v && cur_tag == 0, cur_v && cur_tag == 1});
            chk("p0_rdata", p0_rdata_o, (cur_v && cur_tag == 0) ? cur_data : 32'h0);
            chk("p1_rdata", p1_rdata_o, (cur_v && cur_tag == 1) ? cur_data : 32'h0);

            if (g0 || g1) begin
                if (we) begin
                    if (a < 32'h4000) exp_mem[a[13:2]] = wd;
                    nd = 32'hfa11_1eaf;
                end else begin
                    nd = (a < 32'h4000) ? exp_mem[a[13:2]] : 32'hdead_beef;
                end
                cur_v = 1; cur_tag = g1 ? 1 : 0; cur_data = nd;
            end else begin
                cur_v = 0;
            end

            if (m_owner < 0) begin
                if (p0_req_i && p1_req_i) m_last = g1 ? 1 : 0;
                if (g0 && p0_lock_i) begin m_owner = 0; m_held = 0; end
                else if (g1 && p1_lock_i) begin m_owner = 1; m_held = 0; end
            end else begin
                lk = (m_owner == 0) ? p0_lock_i : p1_lock_i;
                rq = (m_owner == 0) ? p0_req_i  : p1_req_i;
                gn = (m_owner == 0) ? g0 : g1;
                if (m_held == LM - 1) begin m_last = m_owner; m_owner = -1; end
                else if (!lk && (gn || !rq)) m_owner = -1;
                else m_held++;
            end
            m_g0 = g0; m_g1 = g1;
        end
    end

    task automatic cyc();
        @(posedge clk_i); #1;
    endtask

    task automatic drv0(input bit r, input bit w, input bit l, input logic [31:0] a, input logic [31:0] d);
        p0_req_i = r; p0_we_i = w; p0_lock_i = l; p0_addr_i = a; p0_wdata_i = d;
    endtask

    task automatic drv1(input bit r, input bit w, input bit l, input logic [31:0] a, input logic [31:0] d);
        p1_req_i = r; p1_we_i = w; p1_lock_i = l; p1_addr_i = a; p1_wdata_i = d;
    endtask

    function automatic logic [31:0] pick_addr();
        if ($urandom_range(0, 15) == 0) return 32'h4000 + ($urandom_range(0, 15) << 2);
        return $urandom_range(0, 31) << 2;
    endfunction

    initial begin
        logic [7:0] pat;
        int         p1_cnt;
        for (int i = 0; i < 4096; i++) begin mem[i] = '0; exp_mem[i] = '0; end
        drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // write then read back through the other port
        drv0(1, 1, 0, 32'h10, 32'h1234_5678);
        @(negedge clk_i);
        chk("wr_gnt", {p0_gnt_o, p1_gnt_o}, 2'b10);
        chk("wr_addr", mem_addr_o, 32'h10);
        cyc(); drv0(0, 0, 0, 0, 0); drv1(1, 0, 0, 32'h10, 0);
        @(negedge clk_i);
        chk("rd_gnt_p1", p1_gnt_o, 1'b1);
        chk("wr_ack", p0_rdata_o, 32'hfa11_1eaf);
        cyc(); drv1(0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("rd_data", p1_rdata_o, 32'h1234_5678);
        chk("rd_valid", {p0_rvalid_o, p1_rvalid_o}, 2'b01);

        // four-cycle tie
        cyc(); drv0(1, 0, 0, 32'h10, 0); drv1(1, 0, 0, 32'h14, 0);
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            pat = {p1_gnt_o, p0_gnt_o, pat[7:2]};
            if (i < 3) cyc();
        end
`ifdef DMEM_ARB_RR_EN
        chk("tie_pattern", pat, 8'h99);
`else
        chk("tie_pattern", pat, 8'h55);
`endif

        // out-of-range read
        cyc(); drv0(0, 0, 0, 0, 0); drv1(1, 0, 0, 32'h4000, 0);
        @(negedge clk_i);
        chk("oor_gnt", p1_gnt_o, 1'b1);
        cyc(); drv1(0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("oor_data", p1_rdata_o, 32'hdead_beef);
        chk("oor_p0", p0_rvalid_o, 1'b0);

        // locked read-modify-write
        cyc(); drv0(1, 0, 1, 32'h20, 0);
        @(negedge clk_i);
        chk("lk_gnt0", p0_gnt_o, 1'b1);
        cyc(); drv0(0, 0, 1, 32'h20, 0); drv1(1, 0, 0, 32'h10, 0);
        @(negedge clk_i);
        chk("lk_stall", p1_gnt_o, 1'b0);
        cyc(); drv0(1, 1, 0, 32'h20, 32'hcafe_0001);
        @(negedge clk_i);
        chk("lk_wr", {p1_gnt_o, p0_gnt_o}, 2'b01);
        cyc(); drv0(0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("lk_after", p1_gnt_o, 1'b1);
        cyc(); drv1(0, 0, 0, 0, 0);

        // lock timeout
        drv0(1, 0, 1, 32'h24, 0);
        @(negedge clk_i);
        chk("to_first", p0_gnt_o, 1'b1);
        p1_cnt = 0;
        for (int i = 1; i <= LM; i++) begin
            cyc(); drv1(1, 0, 0, 32'h28, 0);
            @(negedge clk_i);
            if (p1_gnt_o) p1_cnt++;
        end
        chk("to_stall", p1_cnt, 0);
        cyc();
        @(negedge clk_i);
`ifdef DMEM_ARB_RR_EN
        chk("to_release", {p1_gnt_o, p0_gnt_o}, 2'b10);
`else
        chk("to_release", {p1_gnt_o, p0_gnt_o}, 2'b01);
`endif
        cyc(); drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
        repeat (2) cyc();

        // reset right after a grant
        drv0(1, 0, 0, 32'h10, 0);
        @(negedge clk_i);
        chk("rm_gnt", p0_gnt_o, 1'b1);
        cyc(); rst_i = 1'b1; drv0(0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("rm_no_rvalid", p0_rvalid_o, 1'b0);
        cyc(); rst_i = 1'b0; drv0(1, 0, 0, 32'h10, 0); drv1(1, 0, 0, 32'h14, 0);
        @(negedge clk_i);
        chk("rm_tie_p0", {p1_gnt_o, p0_gnt_o}, 2'b01);
        cyc(); drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);

        // random traffic; a pending request keeps its fields until granted
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (!p0_req_i || m_g0)
                drv0($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 5) == 0, pick_addr(), $urandom);
            if (!p1_req_i || m_g1)
                drv1($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 5) == 0, pick_addr(), $urandom);
        end
        cyc(); drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
